// File: rtl/sprite_compositor.sv
// sprite_compositor
//
// Composites Barry and up to NUM_OBS obstacles per VGA pixel in a 2-stage
// pipeline, tracks per-frame collisions and runs the lives/invulnerability FSM.
//
// Ports:
//   clk_i, rst_ni            pixel clock, asynchronous active-low reset
//   frame_start_i            one-cycle pulse before pixel (0,0); never with pixel_valid_i
//   restart_i                one-cycle pulse; honoured only in DONE
//   pixel_valid_i, x_i, y_i  pixel coordinate stream
//   barry_*_i, thrust_i      Barry bounding box and jetpack fire (used live)
//   obs_*_i                  obstacle descriptors, slot i at [i*W +: W]; shadowed per frame
//   r_o, g_o, b_o            registered pixel colour, valid with out_valid_o (latency 2)
//   game_over_o              high in DONE
//   lives_o                  remaining lives
//   hit_o                    one-cycle pulse when a life is lost
module sprite_compositor #(
    parameter int unsigned NUM_OBS       = 4,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    localparam int unsigned LW           = $clog2(LIVES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   frame_start_i,
    input  logic                   restart_i,
    input  logic                   pixel_valid_i,
    input  logic [9:0]             x_i,
    input  logic [8:0]             y_i,
    input  logic [9:0]             barry_x0_i,
    input  logic [9:0]             barry_x1_i,
    input  logic [8:0]             barry_y0_i,
    input  logic [8:0]             barry_y1_i,
    input  logic                   thrust_i,
    input  logic [NUM_OBS-1:0]     obs_en_i,
    input  logic [2*NUM_OBS-1:0]   obs_shape_i,
    input  logic [NUM_OBS-1:0]     obs_flick_i,
    input  logic [10*NUM_OBS-1:0]  obs_x0_i,
    input  logic [10*NUM_OBS-1:0]  obs_x1_i,
    input  logic [9*NUM_OBS-1:0]   obs_y0_i,
    input  logic [9*NUM_OBS-1:0]   obs_y1_i,
    output logic [7:0]             r_o,
    output logic [7:0]             g_o,
    output logic [7:0]             b_o,
    output logic                   out_valid_o,
    output logic                   game_over_o,
    output logic [LW-1:0]          lives_o,
    output logic                   hit_o
);

    localparam logic [23:0] ColYellow   = 24'hFFFF00;
    localparam logic [23:0] ColOrange   = 24'hFF8000;
    localparam logic [23:0] ColHead     = 24'hA4674A;
    localparam logic [23:0] ColTorso    = 24'h0A0A80;
    localparam logic [23:0] ColJetpack  = 24'h141414;
    localparam logic [23:0] ColBg       = 24'hF0F0F0;
    localparam logic [23:0] ColDoneBody = 24'h0000FF;

    typedef enum logic [1:0] {StPlay, StHit, StDone} state_e;

    // ------------------------------------------------------------------
    // Obstacle shadow, loaded only on frame_start so mid-frame edits never tear
    // ------------------------------------------------------------------
    logic [NUM_OBS-1:0]    sh_en_q;
    logic [2*NUM_OBS-1:0]  sh_shape_q;
    logic [NUM_OBS-1:0]    sh_flick_q;
    logic [10*NUM_OBS-1:0] sh_x0_q, sh_x1_q;
    logic [9*NUM_OBS-1:0]  sh_y0_q, sh_y1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_en_q    <= '0;
            sh_shape_q <= '0;
            sh_flick_q <= '0;
            sh_x0_q    <= '0;
            sh_x1_q    <= '0;
            sh_y0_q    <= '0;
            sh_y1_q    <= '0;
        end else if (frame_start_i) begin
            sh_en_q    <= obs_en_i;
            sh_shape_q <= obs_shape_i;
            sh_flick_q <= obs_flick_i;
            sh_x0_q    <= obs_x0_i;
            sh_x1_q    <= obs_x1_i;
            sh_y0_q    <= obs_y0_i;
            sh_y1_q    <= obs_y1_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: region flags. Everything widened to 11 bits so offsets never wrap.
    // ------------------------------------------------------------------
    logic [10:0] px, py, bx0, bx1, by0, by1;
    logic        in_x_left, in_x_right;
    logic        jet_d, fire_d, head_d, torso_d, body_d;

    assign px  = {1'b0, x_i};
    assign py  = {2'b0, y_i};
    assign bx0 = {1'b0, barry_x0_i};
    assign bx1 = {1'b0, barry_x1_i};
    assign by0 = {2'b0, barry_y0_i};
    assign by1 = {2'b0, barry_y1_i};

    assign in_x_left  = (px >= bx0) && (px <= bx0 + 11'd9);
    assign in_x_right = (px >= bx0 + 11'd10) && (px <= bx1);

    assign jet_d   = in_x_left && (py >= by0 + 11'd10) && (py <= by0 + 11'd45);
    assign fire_d  = in_x_left && (py >= by0 + 11'd46) && (py <= by1) && thrust_i;
    assign head_d  = in_x_right && (py >= by0) && (py <= by0 + 11'd15);
    assign torso_d = in_x_right && (py >= by0 + 11'd16) && (py <= by1);
    // Fire is decoration only and never collides
    assign body_d  = jet_d || head_d || torso_d;

    logic [10:0] ox0, ox1, oy0, oy1, dx, dy;
    logic [1:0]  oshape;
    logic        obox, oin;
    logic        obs_d, flick_d;

    always_comb begin
        obs_d   = 1'b0;
        flick_d = 1'b0;
        ox0     = '0;
        ox1     = '0;
        oy0     = '0;
        oy1     = '0;
        dx      = '0;
        dy      = '0;
        oshape  = '0;
        obox    = 1'b0;
        oin     = 1'b0;
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            ox0    = {1'b0, sh_x0_q[i*10 +: 10]};
            ox1    = {1'b0, sh_x1_q[i*10 +: 10]};
            oy0    = {2'b0, sh_y0_q[i*9 +: 9]};
            oy1    = {2'b0, sh_y1_q[i*9 +: 9]};
            oshape = sh_shape_q[i*2 +: 2];
            obox   = sh_en_q[i] && (oshape != 2'b11) &&
                     (px >= ox0) && (px <= ox1) && (py >= oy0) && (py <= oy1);
            // Only meaningful when obox holds, so these never underflow where used
            dx     = px - ox0;
            dy     = py - oy0;
            unique case (oshape)
                2'b01:   oin = obox && (dy <= dx);
                2'b10:   oin = obox && (py + dx >= oy1);
                default: oin = obox;
            endcase
            // Lowest index wins colour selection
            if (oin && !obs_d) begin
                flick_d = sh_flick_q[i];
            end
            obs_d = obs_d || oin;
        end
    end

    logic v1_q, jet1_q, fire1_q, head1_q, torso1_q, obs1_q, flick1_q, coll1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            jet1_q   <= 1'b0;
            fire1_q  <= 1'b0;
            head1_q  <= 1'b0;
            torso1_q <= 1'b0;
            obs1_q   <= 1'b0;
            flick1_q <= 1'b0;
            coll1_q  <= 1'b0;
        end else begin
            v1_q     <= pixel_valid_i;
            jet1_q   <= jet_d;
            fire1_q  <= fire_d;
            head1_q  <= head_d;
            torso1_q <= torso_d;
            obs1_q   <= obs_d;
            flick1_q <= flick_d;
            coll1_q  <= pixel_valid_i && body_d && obs_d;
        end
    end

    // ------------------------------------------------------------------
    // Lives / invulnerability FSM
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [LW-1:0] lives_q;
    logic [7:0]    inv_cnt_q;
    logic [7:0]    frame_cnt_q;
    logic          hit_pending_q;
    logic          hit_q;
    logic          game_over_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StPlay;
            lives_q       <= LW'(LIVES);
            inv_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            hit_pending_q <= 1'b0;
            hit_q         <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (coll1_q && (state_q == StPlay)) begin
                hit_pending_q <= 1'b1;
            end
            if (frame_start_i) begin
                frame_cnt_q   <= frame_cnt_q + 8'd1;
                hit_pending_q <= 1'b0;
                unique case (state_q)
                    StPlay: begin
                        if (hit_pending_q) begin
                            lives_q <= lives_q - LW'(1);
                            hit_q   <= 1'b1;
                            if (lives_q == LW'(1)) begin
                                state_q     <= StDone;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q   <= StHit;
                                inv_cnt_q <= 8'(INVULN_FRAMES);
                            end
                        end
                    end
                    StHit: begin
                        inv_cnt_q <= inv_cnt_q - 8'd1;
                        if (inv_cnt_q == 8'd1) begin
                            state_q <= StPlay;
                        end
                    end
                    default: ;
                endcase
            end
            if (restart_i && (state_q == StDone)) begin
                state_q       <= StPlay;
                lives_q       <= LW'(LIVES);
                hit_pending_q <= 1'b0;
                game_over_q   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour mux, using the FSM state current at this stage
    // ------------------------------------------------------------------
    logic        blank;
    logic        body1;
    logic [23:0] rgb_d;

    assign blank = (state_q == StHit) && frame_cnt_q[2];
    assign body1 = jet1_q || head1_q || torso1_q;

    always_comb begin
        rgb_d = ColBg;
        if (state_q == StDone) begin
            if (body1) begin
                rgb_d = ColDoneBody;
            end
        end else if (obs1_q) begin
            rgb_d = flick1_q ? ColOrange : ColYellow;
        end else if (!blank) begin
            if (fire1_q) begin
                rgb_d = ColOrange;
            end else if (head1_q) begin
                rgb_d = ColHead;
            end else if (torso1_q) begin
                rgb_d = ColTorso;
            end else if (jet1_q) begin
                rgb_d = ColJetpack;
            end
        end
    end

    logic        v2_q;
    logic [23:0] rgb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            v2_q <= v1_q;
            // Hold the last colour between valid pixels
            if (v1_q) begin
                rgb_q <= rgb_d;
            end
        end
    end

    assign r_o         = rgb_q[23:16];
    assign g_o         = rgb_q[15:8];
    assign b_o         = rgb_q[7:0];
    assign out_valid_o = v2_q;
    assign game_over_o = game_over_q;
    assign lives_o     = lives_q;
    assign hit_o       = hit_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (NUM_OBS=4, LIVES=3, INVULN_FRAMES=60).
// Expected colours are queued with their due cycle when a pixel is driven and
// popped when out_valid appears.
module tb_sprite_compositor;

    localparam logic [23:0] YEL  = 24'hFFFF00;
    localparam logic [23:0] ORG  = 24'hFF8000;
    localparam logic [23:0] HEAD = 24'hA4674A;
    localparam logic [23:0] TRS  = 24'h0A0A80;
    localparam logic [23:0] JET  = 24'h141414;
    localparam logic [23:0] BG   = 24'hF0F0F0;
    localparam logic [23:0] DONE = 24'h0000FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, restart, pixel_valid, thrust;
    logic [9:0]  x, bx0, bx1;
    logic [8:0]  y, by0, by1;
    logic [3:0]  obs_en, obs_flick;
    logic [7:0]  obs_shape;
    logic [39:0] obs_x0, obs_x1;
    logic [35:0] obs_y0, obs_y1;
    logic [7:0]  r, g, b;
    logic        out_valid, game_over, hit;
    logic [1:0]  lives;

    always #5 clk = ~clk;

    sprite_compositor #(
        .NUM_OBS      (4),
        .LIVES        (3),
        .INVULN_FRAMES(60)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_start_i(frame_start),
        .restart_i    (restart),
        .pixel_valid_i(pixel_valid),
        .x_i          (x),
        .y_i          (y),
        .barry_x0_i   (bx0),
        .barry_x1_i   (bx1),
        .barry_y0_i   (by0),
        .barry_y1_i   (by1),
        .thrust_i     (thrust),
        .obs_en_i     (obs_en),
        .obs_shape_i  (obs_shape),
        .obs_flick_i  (obs_flick),
        .obs_x0_i     (obs_x0),
        .obs_x1_i     (obs_x1),
        .obs_y0_i     (obs_y0),
        .obs_y1_i     (obs_y1),
        .r_o          (r),
        .g_o          (g),
        .b_o          (b),
        .out_valid_o  (out_valid),
        .game_over_o  (game_over),
        .lives_o      (lives),
        .hit_o        (hit)
    );

    typedef struct {
        logic [23:0] rgb;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   fcnt   = 0;
    logic blank;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and retire any produced pixel.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out observed=%0h expected=none", {r, g, b});
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "_rgb"}, {8'h0, r, g, b}, {8'h0, e.rgb});
                chk({e.tag, "_lat"}, cyc, e.due);
            end
        end
        if (sb.size() != 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.due >= cyc) else begin
                errors++;
                $error("FAIL %s_missing observed=no_output expected=%0h", e.tag, e.rgb);
            end
        end
    endtask

    task automatic pix(input int px, input int py, input logic [23:0] exp, input string tag);
        exp_t e;
        x           = px[9:0];
        y           = py[8:0];
        pixel_valid = 1'b1;
        e.rgb = exp;
        e.due = cyc + 2;
        e.tag = tag;
        sb.push_back(e);
        tick();
        pixel_valid = 1'b0;
    endtask

    // Two idle cycles guarantee the last pixel's collision is sampled.
    task automatic fs();
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fcnt++;
    endtask

    task automatic set_obs(input int i, input logic en, input logic [1:0] shape,
                           input logic flick, input int x0, input int x1,
                           input int y0, input int y1);
        obs_en[i]          = en;
        obs_shape[i*2 +: 2] = shape;
        obs_flick[i]       = flick;
        obs_x0[i*10 +: 10] = x0[9:0];
        obs_x1[i*10 +: 10] = x1[9:0];
        obs_y0[i*9 +: 9]   = y0[8:0];
        obs_y1[i*9 +: 9]   = y1[8:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; restart = 1'b0; pixel_valid = 1'b0;
        thrust = 1'b0; x = '0; y = '0;
        bx0 = 10'd20; bx1 = 10'd49; by0 = 9'd300; by1 = 9'd380;
        obs_en = '0; obs_flick = '0; obs_shape = '0;
        obs_x0 = '0; obs_x1 = '0; obs_y0 = '0; obs_y1 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_rgb", {8'h0, r, g, b}, 0);
        chk("rst_go", 32'(game_over), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_lives", 32'(lives), 3);
        rst_n = 1'b1;
        tick();

        // Rectangle
        set_obs(0, 1'b1, 2'b00, 1'b0, 100, 149, 200, 219);
        fs();
        pix(120, 210, YEL, "rect_in");
        pix(99, 210, BG, "rect_left");
        pix(149, 219, YEL, "rect_corner");
        pix(150, 210, BG, "rect_right");

        // Falling triangle, plus a shape-11 slot that must stay invisible
        set_obs(1, 1'b1, 2'b01, 1'b0, 300, 349, 100, 150);
        set_obs(2, 1'b1, 2'b11, 1'b0, 500, 520, 10, 20);
        fs();
        pix(310, 105, YEL, "fall_in");
        pix(305, 110, BG, "fall_out");
        pix(510, 15, BG, "shape11");

        // Rising triangle, flicker colour
        set_obs(1, 1'b1, 2'b10, 1'b1, 300, 349, 100, 150);
        fs();
        pix(310, 145, ORG, "rise_in");
        pix(302, 140, BG, "rise_out");

        // Barry regions
        pix(25, 320, JET, "jetpack");
        pix(29, 345, JET, "jet_edge");
        pix(40, 305, HEAD, "head");
        pix(30, 315, HEAD, "head_edge");
        pix(30, 316, TRS, "torso_edge");
        pix(50, 305, BG, "barry_right");
        pix(25, 360, BG, "fire_off");
        thrust = 1'b1;
        pix(29, 346, ORG, "fire_on");
        thrust = 1'b0;

        // Overlap: obs0 beats obs2 on the torso, then a life is lost
        set_obs(0, 1'b1, 2'b00, 1'b0, 35, 45, 340, 360);
        set_obs(1, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
        set_obs(2, 1'b1, 2'b00, 1'b1, 30, 49, 330, 370);
        fs();
        pix(40, 350, YEL, "prio_obs0");
        pix(32, 335, ORG, "obs2_only");
        fs();
        chk("hit1_pulse", 32'(hit), 1);
        chk("hit1_lives", 32'(lives), 2);
        tick();
        chk("hit1_pulse_end", 32'(hit), 0);

        // Invulnerable frames with blinking Barry
        for (int k = 1; k <= 60; k++) begin
            blank = fcnt[2];
            pix(40, 350, YEL, "inv_obs");
            pix(40, 305, blank ? BG : HEAD, "inv_blink");
            fs();
            chk("inv_hit", 32'(hit), 0);
            chk("inv_lives", 32'(lives), 2);
        end

        // Back in PLAY: a collision costs a life again
        pix(40, 350, YEL, "play_coll");
        fs();
        chk("hit2_pulse", 32'(hit), 1);
        chk("hit2_lives", 32'(lives), 1);
        for (int k = 1; k <= 60; k++) begin
            fs();
        end
        // frame_cnt[2]=1 here, but PLAY never blanks
        pix(40, 305, HEAD, "play_noblink");
        pix(40, 350, YEL, "last_coll");
        fs();
        chk("hit3_pulse", 32'(hit), 1);
        chk("hit3_lives", 32'(lives), 0);
        chk("go_set", 32'(game_over), 1);

        // DONE rendering
        set_obs(1, 1'b1, 2'b00, 1'b0, 100, 149, 200, 219);
        fs();
        chk("done_lives", 32'(lives), 0);
        chk("done_go", 32'(game_over), 1);
        chk("done_nohit", 32'(hit), 0);
        thrust = 1'b1;
        pix(40, 305, DONE, "done_head");
        pix(40, 350, DONE, "done_torso_obs");
        pix(25, 320, DONE, "done_jet");
        pix(120, 210, BG, "done_obs_hidden");
        pix(25, 360, BG, "done_fire");
        thrust = 1'b0;

        // Restart
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_go", 32'(game_over), 0);
        chk("restart_lives", 32'(lives), 3);
        pix(40, 305, HEAD, "restart_head");

        // Mid-frame descriptor change is not seen until the next frame_start
        obs_x0[10 +: 10] = 10'd130;
        pix(120, 210, YEL, "midframe_old");
        fs();
        chk("midframe_nohit", 32'(hit), 0);
        chk("midframe_lives", 32'(lives), 3);
        pix(120, 210, BG, "newframe_out");
        pix(135, 210, YEL, "newframe_in");

        // Reset with pixels in flight
        pix(135, 210, YEL, "pre_rst");
        pix(135, 210, YEL, "inflight");
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_rgb", {8'h0, r, g, b}, 0);
        sb.delete();
        tick();
        chk("rst_mid_hold", 32'(out_valid), 0);
        rst_n = 1'b1;
        fcnt = 0;
        tick();
        chk("rst_mid_lives", 32'(lives), 3);
        chk("rst_mid_go", 32'(game_over), 0);
        // Shadow enables cleared by reset even though obs_en inputs are still set
        pix(135, 210, BG, "rst_shadow_clear");

        repeat (4) tick();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
